// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: instruction field layout,
// opcode constants, FSM states and float-opcode classification.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 6;
    localparam int OPC_W  = 4;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int DST_HI = 11;
    localparam int DST_LO = 6;
    localparam int SRC_HI = 5;
    localparam int SRC_LO = 0;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OPadd  = 4'h0;
    localparam opcode_t OPinvf = 4'h1;
    localparam opcode_t OPaddf = 4'h2;
    localparam opcode_t OPmulf = 4'h3;
    localparam opcode_t OPsub  = 4'h4;
    localparam opcode_t OPand  = 4'h5;
    localparam opcode_t OPor   = 4'h6;
    localparam opcode_t OPany  = 4'h7;
    localparam opcode_t OPshl  = 4'h8;
    localparam opcode_t OPshr  = 4'h9;
    localparam opcode_t OPf2i  = 4'hA;
    localparam opcode_t OPi2f  = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic is_float(input opcode_t op);
        return (op == OPinvf) || (op == OPaddf) || (op == OPmulf) ||
               (op == OPf2i)  || (op == OPi2f);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue sequencer: two combinational read ports,
// one synchronous write port, synchronous clear on reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback sequencer (IDLE->READ->EXEC->WB) driving an external combinational ALU.
// Optional feature: define ALU_ISSUE_FTRAP_EN to trap float opcodes instead of issuing them.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREGS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [4:0]        alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done_valid,
    output logic [REG_AW-1:0] done_dest,
    output logic [DATA_W-1:0] done_value,
    output logic              trap,
    output logic              busy
);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W-1:0] r_alu_in1;
    logic [DATA_W-1:0] r_alu_in2;
    logic [4:0]        r_alu_op;
    logic              r_trap;

    opcode_t           w_opc;
    logic [REG_AW-1:0] w_dest;
    logic [REG_AW-1:0] w_src;
    logic [DATA_W-1:0] w_rd_dest;
    logic [DATA_W-1:0] w_rd_src;
    logic              w_accept;
    logic              w_float;
    logic              w_we;
    logic [REG_AW-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_opc    = r_ir[OPC_HI:OPC_LO];
    assign w_dest   = r_ir[DST_HI:DST_LO];
    assign w_src    = r_ir[SRC_HI:SRC_LO];
    assign w_accept = instr_valid && instr_ready;

`ifdef ALU_ISSUE_FTRAP_EN
    assign w_float = is_float(w_opc);
`else
    assign w_float = 1'b0;
`endif

    // Preload owns the write port in IDLE; writeback owns it in WB unless trapped.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = wr_addr;
        w_wdata = wr_data;
        if (r_state == IDLE) begin
            w_we = wr_en;
        end else if (r_state == WB) begin
            w_we    = !r_trap;
            w_waddr = w_dest;
            w_wdata = r_res;
        end
    end

    alu_regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr_a(w_dest),
        .i_raddr_b(w_src),
        .o_rdata_a(w_rd_dest),
        .o_rdata_b(w_rd_src)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = READ;
            READ:    w_next = w_float ? WB : EXEC;
            EXEC:    w_next = WB;
            WB:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        busy        = 1'b1;
        done_valid  = 1'b0;
        done_dest   = '0;
        done_value  = '0;
        trap        = 1'b0;
        case (r_state)
            IDLE: begin
                instr_ready = !wr_en;
                busy        = 1'b0;
            end
            WB: begin
                done_valid = 1'b1;
                done_dest  = w_dest;
                done_value = r_res;
                trap       = r_trap;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir      <= '0;
            r_res     <= '0;
            r_alu_op  <= '0;
            r_alu_in1 <= '0;
            r_alu_in2 <= '0;
            r_trap    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) r_ir <= instr;
                READ: begin
                    r_trap <= w_float;
                    if (w_float) begin
                        // A trapped op reports Dest unchanged and leaves the ALU drive alone.
                        r_res <= w_rd_dest;
                    end else begin
                        r_alu_op  <= {1'b0, w_opc};
                        r_alu_in1 <= w_rd_dest;
                        r_alu_in2 <= w_rd_src;
                    end
                end
                EXEC:    r_res <= alu_result;
                default: ;
            endcase
        end
    end

    assign alu_op  = r_alu_op;
    assign alu_in1 = r_alu_in1;
    assign alu_in2 = r_alu_in2;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a stand-in combinational ALU.
// Honours ALU_ISSUE_FTRAP_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  alu_op;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [15:0] alu_result;
    logic        done_valid;
    logic [5:0]  done_dest;
    logic [15:0] done_value;
    logic        trap;
    logic        busy;

`ifdef ALU_ISSUE_FTRAP_EN
    localparam bit FTRAP = 1'b1;
`else
    localparam bit FTRAP = 1'b0;
`endif

    typedef struct {
        logic [5:0]  dest;
        logic [15:0] value;
        logic        trap;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] m [64];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          cur_chk = 1'b0;
    int          cur_acc = 0;
    logic [4:0]  cur_op;
    logic [15:0] cur_in1;
    logic [15:0] cur_in2;

    alu_issue dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alu_op     (alu_op),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result),
        .done_valid (done_valid),
        .done_dest  (done_dest),
        .done_value (done_value),
        .trap       (trap),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU: add, any, shr modelled; 3 gives a distinct value; everything else passes in1.
    function automatic logic [15:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op[3:0])
            4'h0:    return a + b;
            4'h3:    return a ^ b;
            4'h7:    return {15'd0, |a};
            4'h9:    return a >> 1;
            default: return a;
        endcase
    endfunction

    function automatic bit is_fl(input logic [3:0] op);
        return op == 4'h1 || op == 4'h2 || op == 4'h3 || op == 4'hA || op == 4'hB;
    endfunction

    assign alu_result = alu_f(alu_op, alu_in1, alu_in2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        instr_valid = 1'b0;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        m[a] = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, output int acc);
        bit          got;
        int          n;
        exp_t        e;
        logic [5:0]  d;
        logic [5:0]  s;
        logic [3:0]  o;
        got = 1'b0; n = 0; acc = -1;
        while (!got && n < 40) begin
            @(negedge clk);
            wr_en = 1'b0; instr = ins; instr_valid = 1'b1;
            #1;
            if (instr_ready) got = 1'b1;
            n++;
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        o = ins[15:12]; d = ins[11:6]; s = ins[5:0];
        e.dest  = d;
        e.acc   = cyc;
        e.trap  = FTRAP && is_fl(o);
        e.value = e.trap ? m[d] : alu_f({1'b0, o}, m[d], m[s]);
        cur_op  = {1'b0, o}; cur_in1 = m[d]; cur_in2 = m[s];
        cur_acc = cyc; cur_chk = !e.trap;
        if (!e.trap) m[d] = e.value;
        sb.push_back(e);
        acc = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        instr_valid = 1'b0; wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run1(input logic [15:0] ins);
        int a;
        issue(ins, a);
        idle();
        drain();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (cur_chk && cyc == cur_acc + 2) begin
                check("exec_op", alu_op, cur_op);
                check("exec_in1", alu_in1, cur_in1);
                check("exec_in2", alu_in2, cur_in2);
                cur_chk = 1'b0;
            end
            if (done_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_done", done_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_dest", done_dest, mon_e.dest);
                    check("done_value", done_value, mon_e.value);
                    check("done_trap", trap, mon_e.trap);
                    check("latency", cyc - mon_e.acc, mon_e.trap ? 2 : 3);
                end
            end else if (trap) begin
                check("trap_without_done", trap, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, c0;
        logic [3:0] ops [8];
        ops[0] = 4'h0; ops[1] = 4'h7; ops[2] = 4'h9; ops[3] = 4'hC;
        ops[4] = 4'hF; ops[5] = 4'h3; ops[6] = 4'hA; ops[7] = 4'h1;
        for (int i = 0; i < 64; i++) m[i] = 16'h0000;
        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0;
        wr_en = 1'b0; wr_addr = 6'h0; wr_data = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done_valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_in1", alu_in1, 0);
        check("rst_alu_in2", alu_in2, 0);
        check("rst_trap", trap, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);

        // add r1 += r2, then read r1 back via a pass-through opcode
        preload(6'd1, 16'h0003);
        preload(6'd2, 16'h0005);
        run1(16'h0042);
        run1(16'hC040);

        // shr and any
        preload(6'd3, 16'h8001);
        run1(16'h90C0);
        preload(6'd4, 16'h0000);
        run1(16'h7105);
        preload(6'd4, 16'h0100);
        run1(16'h7105);

        // mulf: trapped or issued depending on build
        preload(6'd1, 16'h1234);
        preload(6'd2, 16'h00FF);
        run1(16'h3042);
        run1(16'hC040);

        // back-to-back with instr_valid held high
        preload(6'd6, 16'h0001);
        preload(6'd7, 16'h0002);
        issue(16'h01C7, a1);
        issue(16'h01C7, a2);
        idle();
        check("b2b_gap", a2 - a1, 4);
        drain();

        // preload colliding with an offered instruction
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'hBEEF;
        instr = 16'h0145; instr_valid = 1'b1;
        #1 check("coll_ready", instr_ready, 0);
        m[5] = 16'hBEEF;
        c0 = cyc;
        issue(16'h0145, a1);
        idle();
        check("coll_acc", a1, c0 + 1);
        drain();

        // reset while in EXEC
        issue(16'h0042, a1);
        idle();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        cur_chk = 1'b0;
        for (int i = 0; i < 64; i++) m[i] = 16'h0000;
        @(negedge clk);
        check("rx_busy", busy, 0);
        check("rx_done", done_valid, 0);
        check("rx_dest", done_dest, 0);
        check("rx_value", done_value, 0);
        check("rx_alu_op", alu_op, 0);
        check("rx_alu_in1", alu_in1, 0);
        check("rx_alu_in2", alu_in2, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rx_ready", instr_ready, 1);
        run1(16'hC040);
        run1(16'hC140);

        // randomized mix over a few registers
        for (int k = 0; k < 10; k++) begin
            logic [5:0] d;
            logic [5:0] s;
            d = 6'($urandom_range(0, 7));
            s = 6'($urandom_range(0, 7));
            preload(d, 16'($urandom));
            preload(s, 16'($urandom));
            run1({ops[$urandom_range(0, 7)], d, s});
        end

        drain();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Multi-cycle issue/writeback sequencer that sits on the other side of the combinational `alu`. It accepts 16-bit instructions over a valid/ready handshake, decodes the Opcode/Dest/Src fields, and reads both operands from a 64×16 register file. It then drives the ALU's `op`/`in1`/`in2` inputs, captures `result`, writes the result back to the register file, and reports completion.

## Interface
Parameters:
- `NREGS`, 64: register count; must equal 2^6 to match the Dest/Src field width.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `instr_valid`, in, 1: `instr` is offered.
- `instr_ready`, out, 1: block can accept `instr`.
- `instr`, in, 16: Opcode [15:12], Dest [11:6], Src [5:0].
- `wr_en`, in, 1: preload write strobe, honoured only in IDLE.
- `wr_addr`, in, 6: preload register index.
- `wr_data`, in, 16: preload value.
- `alu_op`, out, 5: goes to `alu.op`; equals {1'b0, Opcode}.
- `alu_in1`, out, 16: goes to `alu.in1`; equals regs[Dest].
- `alu_in2`, out, 16: goes to `alu.in2`; equals regs[Src].
- `alu_result`, in, 16: comes from `alu.result`.
- `done_valid`, out, 1: one-cycle completion pulse.
- `done_dest`, out, 6: Dest of the completed instruction.
- `done_value`, out, 16: value now held in regs[Dest].
- `trap`, out, 1: qualifies `done_valid`; the instruction was rejected.
- `busy`, out, 1: state is not IDLE.

## Operation
The block is a four-state FSM: IDLE → READ → EXEC → WB → IDLE.

- **IDLE**
  - `instr_ready = !wr_en`.
  - `wr_en` writes regs[`wr_addr`] = `wr_data`. Preload wins over an instruction offered in the same cycle; that instruction is not accepted.
  - A handshake (`instr_valid && instr_ready`) latches `instr` into the IR and moves to READ.
- **READ**
  - Latches A = regs[Dest], B = regs[Src] into the `alu_in1`/`alu_in2` registers.
  - Latches `alu_op`.
  - Moves to EXEC.
- **EXEC**
  - `alu_op`/`alu_in1`/`alu_in2` are stable for the whole cycle.
  - `alu_result` is captured into R at the edge.
  - Moves to WB.
- **WB**
  - regs[Dest] = R.
  - `done_valid` = 1, `done_dest` = Dest, `done_value` = R, `trap` = 0.
  - Moves to IDLE.

Rules that apply in every state:
- Every instruction is issued unmodified, including opcodes 1100–1111. The ALU default passes `in1` for these, so regs[Dest] is rewritten with its own value.
- Reads in READ see every completed preload or writeback, because at most one instruction is in flight.
- ALU drive outputs hold their last value outside EXEC.
- `done_valid` and `trap` are 0 outside WB.
- All arithmetic happens in `alu`. This block adds no width extension or truncation: the result is stored exactly as returned, 16 bits.

Reset (any state, including mid-instruction):
- Next state is IDLE; the in-flight instruction is dropped with no `done_valid`.
- All registers and outputs reset to 0: regs, IR, A, B, R, `alu_op`, `alu_in1`, `alu_in2`, `done_*`, `trap`, `busy`.
- `instr_ready` is 1 in the cycle after reset is released.

## Timing
- Handshake at edge E0 → READ in the following cycle → EXEC → WB. `done_valid` is high in the cycle following edge E2, i.e. the third cycle after acceptance.
- The written value is visible to the next instruction's READ.
- Throughput is one instruction per 4 cycles. `instr_ready` returns at E3.
- `instr_valid` held high with back-to-back instructions gives acceptances exactly 4 cycles apart.

## Configuration
- `ALU_ISSUE_FTRAP_EN` defined:
  - Float opcodes (0001 invf, 0010 addf, 0011 mulf, 1010 f2i, 1011 i2f) are detected in READ, and the FSM jumps directly to WB.
  - In WB there is no register write: `trap` = 1, `done_valid` = 1, `done_value` = the unchanged regs[Dest].
  - Latency drops to 2 cycles; ALU drive outputs are not updated.
- `ALU_ISSUE_FTRAP_EN` not defined: float opcodes are issued like any other opcode, and `trap` is tied to 0.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode constants OPadd through OPi2f.
  - Field ranges for Opcode/Dest/Src.
  - The state enum IDLE/READ/EXEC/WB.
  - An `is_float(op)` function.
- One sub-module, `alu_regfile`: 64×16, two combinational read ports, one write port, synchronous reset to 0.
- Write-port arbitration (preload vs. writeback) stays in `alu_issue`.
- `alu` is instantiated at the next level up, not inside this block.

## Test plan
- **add:** preload r1 = 0x0003, r2 = 0x0005; issue 0x0042 → in EXEC `alu_op` = 0, `alu_in1` = 3, `alu_in2` = 5; 3 cycles after acceptance `done_valid` = 1, `done_dest` = 1, `done_value` = 0x0008; r1 = 0x0008.
- **shr and any:**
  - r3 = 0x8001, issue 0x90C0 → `done_value` = 0x4000.
  - r4 = 0x0000, issue 0x7105 → 0x0000.
  - r4 = 0x0100 → 0x0001.
- **float trap:** mulf 0x3042 with r1 = 0x1234.
  - Macro defined → `trap` = 1 and `done_valid` 2 cycles after acceptance; r1 stays 0x1234.
  - Macro undefined → issued with `alu_op` = 3, `done_valid` at 3 cycles, `trap` = 0.
- **back-to-back:** `instr_valid` held high → acceptances 4 cycles apart; second instruction reads the first's writeback.
- **preload collision:** in IDLE, `wr_en` = 1 (r5 = 0xBEEF) together with `instr_valid` = 1 → `instr_ready` = 0 that cycle; r5 = 0xBEEF; instruction accepted the next cycle.
- **reset in EXEC:** assert `reset` during EXEC → next cycle IDLE, all outputs 0, regs 0, no `done_valid`; `instr_ready` = 1 after release.
